// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU READ/WRITE requests against a 256-word synchronous RAM plus LED/switch registers.
// Optional build macro MEM_WRPROT_EN adds the wr_protect input guarding RAM words below PROT_BOUND.
module mem_responder #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                READ_LAT = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
`ifdef MEM_WRPROT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_BOUND = 9'h010
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw_in,
`ifdef MEM_WRPROT_EN
  input  logic              wr_protect,
`endif
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic [7:0]        led_out,
  output logic              cmd_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a command is accepted on the rising edge where the FSM is IDLE;
  // mem_ready is a one-cycle pulse marking completion, and read_data is valid
  // during that pulse and held until the next read completes.

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RSVD  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [1:0] LAT       = 2'(READ_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_sw;
  logic [7:0]        r_led;
  logic              r_err;
  logic              r_src_ram;
  logic [DATA_W-1:0] r_io_data;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_ram [0:255];

  logic              w_accept_rd;
  logic              w_accept_wr;
  logic              w_rsvd;
  logic              w_rd_load;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [7:0]        w_sel_sw;
  logic              w_sel_is_ram;
  logic [DATA_W-1:0] w_io_data;
  logic              w_prot_hit;
  logic              w_wr_ram;
  logic              w_wr_led;
  logic              w_ram_we;

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_accept_rd = 1'b0;
    w_accept_wr = 1'b0;
    w_rsvd      = 1'b0;
    w_rd_load   = 1'b0;
    case (r_state)
      IDLE: begin
        case (mem_cmd)
          CMD_READ: begin
            w_accept_rd = 1'b1;
            w_cnt_next  = LAT;
            if (LAT == 2'd0) begin
              w_next    = RD_DONE;
              w_rd_load = 1'b1;
            end else begin
              w_next = RD_WAIT;
            end
          end
          CMD_WRITE: begin
            w_accept_wr = 1'b1;
            w_next      = WR_DONE;
          end
          CMD_RSVD: w_rsvd = 1'b1;
          default: ;
        endcase
      end
      RD_WAIT: begin
        w_cnt_next = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) begin
          w_next    = RD_DONE;
          w_rd_load = 1'b1;
        end
      end
      RD_DONE: w_next = IDLE;
      WR_DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With zero wait states the read resolves on the acceptance edge, so the
  // live request is used instead of the latched copy.
  assign w_sel_addr   = (r_state == IDLE) ? mem_addr : r_addr;
  assign w_sel_sw     = (r_state == IDLE) ? sw_in : r_sw;
  assign w_sel_is_ram = ~w_sel_addr[ADDR_W-1];

  always_comb begin
    w_io_data = '0;
    if (w_sel_addr == SW_ADDR) begin
      w_io_data = {{(DATA_W-8){1'b0}}, w_sel_sw};
    end else if (w_sel_addr == LED_ADDR) begin
      w_io_data = {{(DATA_W-8){1'b0}}, r_led};
    end
  end

`ifdef MEM_WRPROT_EN
  assign w_prot_hit = w_accept_wr & wr_protect & ~mem_addr[ADDR_W-1] &
                      (mem_addr < PROT_BOUND);
`else
  assign w_prot_hit = 1'b0;
`endif

  assign w_wr_ram = w_accept_wr & ~mem_addr[ADDR_W-1] & ~w_prot_hit;
  assign w_wr_led = w_accept_wr & (mem_addr == LED_ADDR);
  // A write presented while reset is held must never reach the array.
  assign w_ram_we = w_wr_ram & reset_n;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[mem_addr[7:0]] <= write_data;
    end
    if (w_rd_load) begin
      r_ram_q <= r_ram[w_sel_addr[7:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_addr    <= '0;
      r_sw      <= 8'h00;
      r_led     <= 8'h00;
      r_err     <= 1'b0;
      r_src_ram <= 1'b0;
      r_io_data <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept_rd) begin
        r_addr <= mem_addr;
        r_sw   <= sw_in;
      end
      if (w_rd_load) begin
        r_src_ram <= w_sel_is_ram;
        r_io_data <= w_io_data;
      end
      if (w_wr_led) begin
        r_led <= write_data[7:0];
      end
      if (w_rsvd | w_prot_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign read_data = r_src_ram ? r_ram_q : r_io_data;
  assign mem_ready = (r_state == RD_DONE) | (r_state == WR_DONE);
  assign led_out   = r_led;
  assign cmd_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder; build with +define+MEM_WRPROT_EN to cover write protection.
module tb_mem_responder;

  localparam int READ_LAT = 1;
  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_RSVD  = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;
  localparam logic [8:0] LED_A   = 9'h100;
  localparam logic [8:0] SW_A    = 9'h140;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_cmd = C_NONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [7:0]  sw_in = '0;
`ifdef MEM_WRPROT_EN
  logic        wr_protect = 1'b0;
`endif
  logic [15:0] read_data;
  logic        mem_ready;
  logic [7:0]  led_out;
  logic        cmd_err;
  logic [1:0]  dbg_state;

  mem_responder #(.READ_LAT(READ_LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_cmd(mem_cmd),
    .mem_addr(mem_addr),
    .write_data(write_data),
    .sw_in(sw_in),
`ifdef MEM_WRPROT_EN
    .wr_protect(wr_protect),
`endif
    .read_data(read_data),
    .mem_ready(mem_ready),
    .led_out(led_out),
    .cmd_err(cmd_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        is_rd;
    logic [15:0] data;
    logic [31:0] acc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [15:0] m_ram [256];
  bit          m_vld [256];
  logic [7:0]  m_led = 8'h00;
  bit          m_err = 1'b0;
  logic [15:0] m_rd  = 16'h0000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_ready: got mem_ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.is_rd ? "rd_latency" : "wr_latency", 32'(cyc + 1 - int'(e.acc)),
              e.is_rd ? 32'(READ_LAT + 1) : 32'd1);
        if (e.is_rd) check("read_data", {16'h0, read_data}, {16'h0, e.data});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_read(input logic [8:0] a, input logic [7:0] sw);
    if (a < 9'h100)    return m_ram[a[7:0]];
    else if (a == SW_A)  return {8'h00, sw};
    else if (a == LED_A) return {8'h00, m_led};
    else                 return 16'h0000;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bit prot;
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    @(posedge clk);
    #1;
    prot = 1'b0;
`ifdef MEM_WRPROT_EN
    prot = wr_protect && (addr < 9'h010);
`endif
    case (cmd)
      C_READ: begin
        m_rd = model_read(addr, sw_in);
        exp_q.push_back({1'b1, m_rd, 32'(cyc)});
      end
      C_WRITE: begin
        if (prot) m_err = 1'b1;
        else if (addr < 9'h100) begin
          m_ram[addr[7:0]] = wd;
          m_vld[addr[7:0]] = 1'b1;
        end
        if (addr == LED_A) m_led = wd[7:0];
        exp_q.push_back({1'b0, 16'h0, 32'(cyc)});
      end
      C_RSVD: m_err = 1'b1;
      default: ;
    endcase
    // Inputs change once the request is taken; the DUT must ignore them.
    mem_cmd    = C_NONE;
    mem_addr   = 9'($urandom);
    write_data = 16'($urandom);
    sw_in      = 8'($urandom);
    if (cmd == C_RSVD || cmd == C_NONE) begin
      repeat (3) @(posedge clk);
    end else begin
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
        check("ready_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
    @(negedge clk);
    check("cmd_err", {31'h0, cmd_err}, {31'h0, m_err});
    check("led_out", {24'h0, led_out}, {24'h0, m_led});
    check("read_hold", {16'h0, read_data}, {16'h0, m_rd});
    check("idle_state", {30'h0, dbg_state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  cmd;
    logic [8:0]  addr;
    int          k;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", {16'h0, read_data}, 32'd0);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'd0);
    check("rst_led_out", {24'h0, led_out}, 32'd0);
    check("rst_cmd_err", {31'h0, cmd_err}, 32'd0);
    check("rst_state", {30'h0, dbg_state}, 32'd0);
    reset_n = 1'b1;

    do_op(C_WRITE, 9'h005, 16'hBEEF);
    do_op(C_READ,  9'h005, 16'h0000);
    do_op(C_WRITE, LED_A,  16'h00A5);
    do_op(C_READ,  LED_A,  16'h0000);
    @(negedge clk);
    sw_in = 8'h3C;
    do_op(C_READ,  SW_A,   16'h0000);
    do_op(C_READ,  9'h1FF, 16'h0000);
    do_op(C_RSVD,  9'h005, 16'h1111);
    do_op(C_READ,  9'h005, 16'h0000);
`ifdef MEM_WRPROT_EN
    do_op(C_WRITE, 9'h003, 16'h0AAA);
    wr_protect = 1'b1;
    do_op(C_WRITE, 9'h003, 16'h1234);
    do_op(C_READ,  9'h003, 16'h0000);
    do_op(C_WRITE, 9'h013, 16'h5678);
    do_op(C_READ,  9'h013, 16'h0000);
    wr_protect = 1'b0;
`endif

    // Reset while a read is waiting: everything clears, no completion.
    @(negedge clk);
    mem_cmd  = C_READ;
    mem_addr = 9'h005;
    @(posedge clk);
    #1;
    mem_cmd = C_NONE;
    reset_n = 1'b0;
    #1;
    check("midrst_read_data", {16'h0, read_data}, 32'd0);
    check("midrst_mem_ready", {31'h0, mem_ready}, 32'd0);
    check("midrst_led_out", {24'h0, led_out}, 32'd0);
    check("midrst_cmd_err", {31'h0, cmd_err}, 32'd0);
    check("midrst_state", {30'h0, dbg_state}, 32'd0);
    m_led = 8'h00;
    m_err = 1'b0;
    m_rd  = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    do_op(C_READ, 9'h005, 16'h0000);

    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(0, 19);
      cmd = ($urandom_range(0, 1) == 1) ? C_READ : C_WRITE;
      if (k < 12)       addr = 9'($urandom_range(0, 31));
      else if (k < 14)  addr = LED_A;
      else if (k < 16)  addr = SW_A;
      else if (k < 19)  addr = {1'b1, 8'($urandom)};
      else begin
        addr = 9'($urandom);
        cmd  = C_RSVD;
      end
      if (cmd == C_READ && addr < 9'h100 && !m_vld[addr[7:0]]) cmd = C_WRITE;
`ifdef MEM_WRPROT_EN
      wr_protect = ($urandom_range(0, 3) == 0);
`endif
      do_op(cmd, addr, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
